// File: rtl/scic_boot_controller.sv
// Boot sequencer for the SCIC core: loads a program image from the host, runs the CPU
// until a halt store or cycle budget, then hands the single-port memory back for readback.
module scic_boot_controller #(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    HALT_ADDR = 16'hFFFF,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   load_len_q;
  logic [CNT_W-1:0]    run_cycles_q;
  logic [CNT_W-1:0]    cycle_count_q;
  logic                halted_q;
  logic                cpu_reset_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic host_side;
  logic start_ok;
  logic accept;
  logic last_word;
  logic halt_hit;
  logic timeout_hit;

  assign host_side   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok    = host_side && start;
  assign accept      = (state_q == S_LOAD) && in_valid;
  assign last_word   = accept && (ptr_q == load_len_q - ADDR_W'(1));
  assign halt_hit    = (state_q == S_RUN) && cpu_we && (cpu_address == HALT_ADDR);
  assign timeout_hit = (state_q == S_RUN) && (run_cycles_q != '0) &&
                       (cycle_count_q == run_cycles_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (load_len != '0) ? S_LOAD : S_RUN;
      S_LOAD:         if (last_word) state_d = S_RUN;
      S_RUN:          if (halt_hit || timeout_hit) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Memory port ownership follows the state: loader, CPU, or host readback.
  always_comb begin
    mem_address = rd_addr;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    case (state_q)
      S_LOAD: begin
        mem_address = ptr_q;
        mem_wdata   = in_data;
        mem_we      = in_valid;
      end
      S_RUN: begin
        mem_address = cpu_address;
        mem_wdata   = cpu_data_out;
        mem_we      = cpu_we && !halt_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      load_len_q    <= '0;
      run_cycles_q  <= '0;
      cycle_count_q <= '0;
      halted_q      <= 1'b0;
      cpu_reset_q   <= 1'b1;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= (state_d != S_RUN);
      rd_valid_q  <= host_side && rd_req;
      if (host_side && rd_req) rd_data_q <= mem_rdata;
      if (start_ok) begin
        load_len_q    <= load_len;
        run_cycles_q  <= run_cycles;
        ptr_q         <= '0;
        cycle_count_q <= '0;
        halted_q      <= 1'b0;
      end
      if (accept) ptr_q <= ptr_q + ADDR_W'(1);
      if (state_q == S_RUN) cycle_count_q <= cycle_count_q + CNT_W'(1);
      if (halt_hit) halted_q <= 1'b1;
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign cpu_reset   = cpu_reset_q;
  assign cpu_data_in = mem_rdata;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_scic_boot_controller.sv
// Directed bench for scic_boot_controller with a behavioural async-read memory and an emulated CPU port.
module tb_scic_boot_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] load_len;
  logic [31:0] run_cycles;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        cpu_reset;
  logic [15:0] cpu_address;
  logic        cpu_we;
  logic [31:0] cpu_data_out;
  logic [31:0] cpu_data_in;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        halted;
  logic [31:0] cycle_count;

  int tests = 0;
  int fails = 0;

  scic_boot_controller dut (
    .clock(clock), .reset(reset), .start(start), .load_len(load_len),
    .run_cycles(run_cycles), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cpu_reset(cpu_reset), .cpu_address(cpu_address),
    .cpu_we(cpu_we), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Memory macro model plus a write log.
  logic [31:0] mem [0:65535];
  logic [15:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int          wr_cnt = 0;
  logic        halt_written = 1'b0;

  initial for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

  assign mem_rdata = mem[mem_address];

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_address] <= mem_wdata;
      wr_addr[wr_cnt[7:0]] <= mem_address;
      wr_data[wr_cnt[7:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (mem_address == 16'hFFFF) halt_written <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] len, input logic [31:0] cyc);
    start = 1'b1; load_len = len; run_cycles = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } run_vec_t;

  run_vec_t    run_tab [0:5];
  logic [31:0] prog [0:2];
  int          base;
  int          n;

  initial begin
    prog[0] = 32'h40000005; prog[1] = 32'h70000010; prog[2] = 32'h7000FFFF;
    // Emulated CPU bus activity for the T1 program; halt store lands on RUN cycle 6.
    run_tab[0] = '{16'h0000, 1'b0, 32'h0, 1'b0, 32'h40000005};
    run_tab[1] = '{16'h0001, 1'b0, 32'h0, 1'b0, 32'h70000010};
    run_tab[2] = '{16'h0010, 1'b1, 32'h5, 1'b1, 32'h00000000};
    run_tab[3] = '{16'h0002, 1'b0, 32'h0, 1'b0, 32'h7000FFFF};
    run_tab[4] = '{16'h0010, 1'b0, 32'h0, 1'b0, 32'h00000005};
    run_tab[5] = '{16'hFFFF, 1'b1, 32'h0, 1'b0, 32'h00000000};

    reset = 1'b1; start = 1'b0; load_len = '0; run_cycles = '0;
    in_valid = 1'b0; in_data = '0; cpu_address = '0; cpu_we = 1'b0;
    cpu_data_out = '0; rd_req = 1'b0; rd_addr = '0;
    tick(); tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_halted", halted, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    reset = 1'b0;
    tick();

    // T1: load three words, run the emulated program to a halt store, read back.
    base = wr_cnt;
    do_start(16'd3, 32'd0);
    check("t1_in_ready", in_ready, 1);
    check("t1_load_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = prog[i];
      #1;
      check($sformatf("t1_load%0d_we", i), mem_we, 1);
      check($sformatf("t1_load%0d_addr", i), mem_address, 16'(i));
      tick();
    end
    in_valid = 1'b0;
    check("t1_run_cpu_reset", cpu_reset, 0);
    check("t1_run_in_ready", in_ready, 0);
    for (int i = 0; i < 6; i++) begin
      cpu_address = run_tab[i].addr; cpu_we = run_tab[i].we; cpu_data_out = run_tab[i].wdata;
      #1;
      check($sformatf("t1_run%0d_cpu_reset", i), cpu_reset, 0);
      check($sformatf("t1_run%0d_mem_we", i), mem_we, run_tab[i].exp_we);
      check($sformatf("t1_run%0d_addr", i), mem_address, run_tab[i].addr);
      check($sformatf("t1_run%0d_rdata", i), cpu_data_in, run_tab[i].exp_rdata);
      tick();
    end
    cpu_we = 1'b0;
    check("t1_done", done, 1);
    check("t1_halted", halted, 1);
    check("t1_cycle_count", cycle_count, 6);
    check("t1_cpu_reset_after", cpu_reset, 1);
    check("t1_busy_after", busy, 0);
    check("t1_wr_cnt", wr_cnt - base, 4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_log%0d_addr", i), wr_addr[base + i], 16'(i));
      check($sformatf("t1_log%0d_data", i), wr_data[base + i], prog[i]);
    end
    check("t1_halt_not_written", halt_written, 0);
    rd_req = 1'b1; rd_addr = 16'h0010;
    tick();
    rd_req = 1'b0;
    check("t1_rd_valid", rd_valid, 1);
    check("t1_rd_data", rd_data, 32'h5);
    tick();
    check("t1_rd_valid_pulse", rd_valid, 0);

    // T2: branch-to-self program with a 10-cycle budget.
    base = wr_cnt;
    do_start(16'd1, 32'd10);
    load_word(32'h80000000);
    n = 0;
    while (cpu_reset == 1'b0 && n < 20) begin
      n++;
      tick();
    end
    check("t2_run_cycles", n, 10);
    check("t2_done", done, 1);
    check("t2_halted", halted, 0);
    check("t2_cycle_count", cycle_count, 10);
    check("t2_wr_data", wr_data[base], 32'h80000000);

    // T3: backpressure, valid on alternate cycles.
    base = wr_cnt;
    do_start(16'd4, 32'd3);
    for (int k = 0; k < 8; k++) begin
      in_valid = k[0]; in_data = 32'hA0 + 32'(k / 2);
      tick();
      if (k == 6) check("t3_still_load", cpu_reset, 1);
    end
    in_valid = 1'b0;
    check("t3_run_after_4th", cpu_reset, 0);
    check("t3_wr_cnt", wr_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_log%0d_addr", i), wr_addr[base + i], 16'(i));
      check($sformatf("t3_log%0d_data", i), wr_data[base + i], 32'hA0 + 32'(i));
    end
    n = 0;
    while (done == 1'b0 && n < 10) begin
      n++;
      tick();
    end
    check("t3_cycle_count", cycle_count, 3);
    check("t3_halted", halted, 0);

    // T4: ignored inputs during LOAD and RUN.
    base = wr_cnt;
    do_start(16'd1, 32'd0);
    rd_req = 1'b1; rd_addr = 16'h0000;
    tick();
    rd_req = 1'b0;
    check("t4_rd_in_load", rd_valid, 0);
    check("t4_still_load", in_ready, 1);
    load_word(32'h12345678);
    start = 1'b1; load_len = 16'd5; in_valid = 1'b1; in_data = 32'hDEAD;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("t4_busy", busy, 1);
    check("t4_in_ready", in_ready, 0);
    check("t4_cpu_reset", cpu_reset, 0);
    check("t4_cycle_count", cycle_count, 1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("t4_rd_in_run", rd_valid, 0);
    check("t4_wr_cnt", wr_cnt - base, 1);
    cpu_we = 1'b1; cpu_address = 16'hFFFF;
    tick();
    cpu_we = 1'b0;
    check("t4_done", done, 1);
    check("t4_cycle_count_end", cycle_count, 3);

    // T5: reset after two of five words, then reload from address 0.
    do_start(16'd5, 32'd0);
    load_word(32'hC0);
    load_word(32'hC1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_done", done, 0);
    base = wr_cnt;
    do_start(16'd2, 32'd0);
    load_word(32'hB0);
    load_word(32'hB1);
    check("t5_log0_addr", wr_addr[base], 16'h0);
    check("t5_log1_addr", wr_addr[base + 1], 16'h1);
    check("t5_run", cpu_reset, 0);
    cpu_we = 1'b1; cpu_address = 16'hFFFF;
    tick();
    cpu_we = 1'b0;
    check("t5_cycle_count", cycle_count, 1);

    // T6: load_len=0 runs on existing memory; halt coincides with timeout cycle.
    do_start(16'd0, 32'd4);
    check("t6_direct_run", cpu_reset, 0);
    check("t6_busy", busy, 1);
    check("t6_in_ready", in_ready, 0);
    cpu_address = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t6_rdata%0d", i), cpu_data_in, 32'hB0);
      tick();
    end
    cpu_we = 1'b1; cpu_address = 16'hFFFF;
    tick();
    cpu_we = 1'b0;
    check("t6_done", done, 1);
    check("t6_halted", halted, 1);
    check("t6_cycle_count", cycle_count, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
